// File: rtl/sipo_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sipo_rx_frame_ctrl
// Description : Serial-frame receive controller sequencing an external
//               clock-enabled SIPO; start/parity/stop checks, valid/ready out.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_rx_frame_ctrl #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Sin,
  input  logic [WIDTH-1:0] Par_In,
  input  logic             Data_Ready,
  output logic             Ser_Out,
  output logic             Shift_En,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Data_Valid,
  output logic             Frame_Err,
  output logic             Parity_Err,
  output logic             Overrun,
  output logic             Busy
);

  localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam int c_IDX_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_HALF_LIM = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_FULL_LIM = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WIDTH - 1);
  localparam logic               c_ODD      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [c_CNT_W-1:0]   r_baud_cnt;
  logic [c_IDX_W-1:0]   r_bit_idx;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_parity_bad;
  logic                 r_overrun;
  logic                 w_shift;
  logic                 w_stop_sample;
  logic                 w_cnt_clr;

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= Sin;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    w_shift       = 1'b0;
    w_stop_sample = 1'b0;
    case (r_state)
      S_IDLE:   if (!r_sync2) w_next_state = S_START;
      S_START:  if (r_baud_cnt == c_HALF_LIM)
                  w_next_state = r_sync2 ? S_IDLE : S_DATA;
      S_DATA:   if (r_baud_cnt == c_FULL_LIM) begin
                  w_shift = 1'b1;
                  if (r_bit_idx == c_LAST_IDX)
                    w_next_state = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
      S_PARITY: if (r_baud_cnt == c_FULL_LIM) w_next_state = S_STOP;
      S_STOP:   if (r_baud_cnt == c_FULL_LIM) begin
                  w_stop_sample = 1'b1;
                  w_next_state  = S_IDLE;
                end
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Divider restarts on any state change and after each data sample.
  assign w_cnt_clr = (w_next_state != r_state) || w_shift;

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      r_baud_cnt   <= '0;
      r_bit_idx    <= '0;
      r_parity_bad <= 1'b0;
    end else begin
      if (w_cnt_clr || r_state == S_IDLE) r_baud_cnt <= '0;
      else                                 r_baud_cnt <= r_baud_cnt + 1'b1;

      if (r_state == S_START) r_bit_idx <= '0;
      else if (w_shift)       r_bit_idx <= r_bit_idx + 1'b1;

      if (r_state == S_START)
        r_parity_bad <= 1'b0;
      else if (r_state == S_PARITY && r_baud_cnt == c_FULL_LIM)
        r_parity_bad <= (^Par_In) ^ r_sync2 ^ c_ODD;
    end
  end

  // A completed word is dropped only when the previous one is still held.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      Data_Out   <= '0;
      Data_Valid <= 1'b0;
      Frame_Err  <= 1'b0;
      Parity_Err <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_stop_sample) begin
        if (!Data_Valid || Data_Ready) begin
          Data_Out   <= Par_In;
          Data_Valid <= 1'b1;
          Frame_Err  <= ~r_sync2;
          Parity_Err <= r_parity_bad;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (Data_Valid && Data_Ready) begin
        Data_Valid <= 1'b0;
      end
    end
  end

  assign Ser_Out  = r_sync2;
  assign Shift_En = w_shift;
  assign Overrun  = r_overrun;
  assign Busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/sipo_rx_frame_ctrl.md
Name: sipo_rx_frame_ctrl

Overview:
Serial-frame receive controller that sequences the team's clock-enabled 4-bit SIPO shift register.
- Detects a start bit on an idle-high serial line and times mid-bit sampling with a clock divider.
- Pulses the SIPO shift enable once per data bit, then checks optional parity and the stop bit.
- Hands the assembled parallel word downstream over a valid/ready handshake.
- Sits between a pad-level serial input and the parallel consumer logic.

Parameters:
- WIDTH, 4, data bits per frame; equals SIPO width.
- CLKS_PER_BIT, 16, clock cycles per serial bit; even, >=4.
- PARITY_EN, 0, 1 = one parity bit follows the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0).

Ports:
- Clock  in  1  rising-edge clock.
- Clear  in  1  asynchronous, active-high reset.
- Sin  in  1  raw serial line; idle high.
- Par_In  in  WIDTH  parallel output of the SIPO.
- Data_Ready  in  1  consumer accepts Data_Out.
- Ser_Out  out  1  synchronized serial bit; drives the SIPO serial input.
- Shift_En  out  1  SIPO shift enable; one-cycle pulse per data bit.
- Data_Out  out  WIDTH  received word.
- Data_Valid  out  1  Data_Out holds an unconsumed word.
- Frame_Err  out  1  stop bit sampled 0; qualifies Data_Out.
- Parity_Err  out  1  parity mismatch; qualifies Data_Out.
- Overrun  out  1  one-cycle pulse: completed word dropped.
- Busy  out  1  state != IDLE.

Behaviour:
- Reset (Clear=1, async):
  - state=IDLE; the 2-flop synchronizer resets to 1, so Ser_Out=1.
  - Shift_En=0, Data_Out=0, Data_Valid=0, Frame_Err=0, Parity_Err=0, Overrun=0, Busy=0.
  - Clear asserted mid-frame aborts the frame, discards the partial word and deasserts Data_Valid.
- Input synchronization: Sin passes through 2 flops; Ser_Out = second flop; all decisions use Ser_Out.
- Divider: baud_cnt counts in START/DATA/PARITY/STOP and clears on every state change. A "sample edge" is the edge on which baud_cnt reaches the dwell limit.
- State transitions (C = CLKS_PER_BIT):
  - IDLE: at an edge with Ser_Out=0 -> START; call this edge E.
  - START: dwell C/2 cycles; sample edge E+C/2.
    - Ser_Out=0 -> DATA, bit_idx=0.
    - Ser_Out=1 (glitch) -> IDLE, no shift.
  - DATA: sample every C cycles, at E+C/2+k*C for k=1..WIDTH.
    - Shift_En=1 combinationally during the cycle ending at each data sample edge, so the SIPO captures Ser_Out on that edge.
    - After the WIDTH-th shift -> PARITY if PARITY_EN, else STOP.
  - PARITY: sample after C cycles. parity_bad = (^Par_In ^ Ser_Out ^ PARITY_ODD) != 0. -> STOP.
  - STOP: sample after C cycles; Frame_Err_next = ~Ser_Out. -> IDLE on the same edge.
- Bit order: the first data bit received ends in Par_In[WIDTH-1]; the last ends in Par_In[0].
- Delivery, on the stop sample edge:
  - If Data_Valid=0, or Data_Valid&Data_Ready in that cycle: Data_Out<=Par_In, Data_Valid<=1, Frame_Err/Parity_Err <= this frame's results.
  - Else: Overrun pulses 1 for one cycle. Data_Out and flags hold the old word; the new word is dropped.
- Handshake:
  - Word consumed on an edge with Data_Valid&Data_Ready. Data_Valid then falls, unless a new word loads on the same edge (back-to-back: stays 1).
  - Data_Out and the error flags stay stable while Data_Valid=1 and not consumed.
- Latency: from the edge on which the first synchronizer flop captures the start 0 to Data_Valid=1 is exactly 2 + C/2 + (WIDTH+PARITY_EN+1)*C edges. Default: 90.
- The next frame's start bit may begin immediately after the stop sample edge; IDLE re-arms with no dead cycles.
- Shift_En is never asserted outside DATA; exactly WIDTH pulses per accepted start.

Test Plan:
- Defaults, frame start0, data 1,0,1,0, stop1, Data_Ready=1 -> 4 Shift_En pulses 16 cycles apart; Data_Valid high 90 edges after capture; Data_Out=4'hA; Frame_Err=0, Parity_Err=0.
- Sin low for 3 cycles then high (glitch) -> START aborts at E+8 to IDLE; no Shift_En; Busy returns to 0; Data_Valid stays 0.
- Frame data 4'h5 with stop bit 0 -> Data_Out=4'h5, Data_Valid=1, Frame_Err=1.
- PARITY_EN=1 even: data 4'hB with parity bit 1 -> Parity_Err=0; same data with parity bit 0 -> Parity_Err=1; Data_Valid 106 edges after capture.
- Data_Ready=0; send 4'h3 then 4'hC back-to-back -> Data_Out stays 4'h3; one Overrun pulse at the second stop sample edge. Then raise Data_Ready -> Data_Valid falls on the next edge.
- Clear pulsed after the 2nd Shift_En of a frame, then a clean 4'h6 frame -> all outputs 0 during reset; no Data_Valid from the aborted frame; next frame yields 4'h6.
